// File: rtl/iobus_pkg.sv
// Shared definitions for MicroBlaze MCS IO bus peripherals: register offsets,
// CTRL bit positions and the byte-lane write merge.
package iobus_pkg;

   localparam logic [2:0] OFS_CTRL     = 3'd0;
   localparam logic [2:0] OFS_LOAD     = 3'd1;
   localparam logic [2:0] OFS_COUNT    = 3'd2;
   localparam logic [2:0] OFS_STATUS   = 3'd3;
   localparam logic [2:0] OFS_PRESCALE = 3'd4;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;

   function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_val;
      for (int i = 0; i < 4; i++)
         if (be[i]) merged[8*i +: 8] = new_val[8*i +: 8];
      return merged;
   endfunction

endpackage

// File: rtl/iobus_if.sv
// MicroBlaze MCS IO bus signal bundle; the CPU side is master, peripherals are slaves.
interface iobus_if;
   logic        io_addr_strobe;
   logic        io_read_strobe;
   logic        io_write_strobe;
   logic [31:0] io_address;
   logic [3:0]  io_byte_enable;
   logic [31:0] io_write_data;
   logic [31:0] io_read_data;
   logic        io_ready;

   modport master (
      output io_addr_strobe, io_read_strobe, io_write_strobe,
             io_address, io_byte_enable, io_write_data,
      input  io_read_data, io_ready
   );

   modport slave (
      input  io_addr_strobe, io_read_strobe, io_write_strobe,
             io_address, io_byte_enable, io_write_data,
      output io_read_data, io_ready
   );
endinterface

// File: rtl/iobus_slave_if.sv
// Reusable IO bus responder front end: window decode, one-cycle ready pipeline
// and read-data gating. The peripheral supplies read data combinationally.
module iobus_slave_if #(
   parameter logic [31:0] BASE_ADDRESS   = 32'hC0003000,
   parameter logic [31:0] ADDRESS_STRIDE = 32'h1000
) (
   input  logic       io_clk,
   input  logic       io_rst,
   iobus_if.slave     bus,
   output logic       o_wr,
   output logic       o_reg_hit,
   output logic [2:0] o_reg_idx,
   input  logic [31:0] i_rd_data
);

   localparam logic [31:0] OFS_MASK = ADDRESS_STRIDE - 32'd1;

   logic        w_sel;
   logic        w_rd;
   logic [26:0] w_ofs_hi;
   logic        r_ready;
   logic [31:0] r_rdata;

   assign w_sel = bus.io_addr_strobe &&
                  ((bus.io_address & ~OFS_MASK) == BASE_ADDRESS);

   // A combined read+write strobe is a write and returns zero data.
   assign o_wr = w_sel && bus.io_write_strobe;
   assign w_rd = w_sel && bus.io_read_strobe && !bus.io_write_strobe;

   // Only the first eight words decode to registers; the rest of the window is empty.
   assign w_ofs_hi  = bus.io_address[31:5] & OFS_MASK[31:5];
   assign o_reg_hit = (w_ofs_hi == '0);
   assign o_reg_idx = bus.io_address[4:2];

   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         r_ready <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ready <= w_sel;
         r_rdata <= w_rd ? i_rd_data : '0;
      end
   end

   assign bus.io_ready     = r_ready;
   assign bus.io_read_data = r_ready ? r_rdata : '0;

endmodule

// File: rtl/iobus_timer.sv
// Down-counting timer on the MCS IO bus: prescaler, load/auto-reload,
// sticky expiry flag and registered level interrupt.
module iobus_timer
   import iobus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS   = 32'hC0003000,
   parameter logic [31:0] ADDRESS_STRIDE = 32'h1000,
   parameter int          PRESCALE_WIDTH = 16
) (
   input  logic   io_clk,
   input  logic   io_rst,
   iobus_if.slave bus,
   output logic   irq
);

   logic                      w_wr;
   logic                      w_reg_hit;
   logic [2:0]                w_reg_idx;
   logic [31:0]               w_rd_data;
   logic [31:0]               w_wdata;
   logic [3:0]                w_be;
   logic                      w_wr_ctrl;
   logic                      w_wr_load;
   logic                      w_wr_count;
   logic                      w_wr_pre;
   logic                      w_status_clr;
   logic                      w_tick;
   logic                      w_expire;
   logic [PRESCALE_WIDTH-1:0] w_pre_wr_val;

   logic                      r_en;
   logic                      r_auto;
   logic                      r_irq_en;
   logic [31:0]               r_load;
   logic [31:0]               r_count;
   logic                      r_expired;
   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic [PRESCALE_WIDTH-1:0] r_pre_cnt;
   logic                      r_irq;

   iobus_slave_if #(
      .BASE_ADDRESS   (BASE_ADDRESS),
      .ADDRESS_STRIDE (ADDRESS_STRIDE)
   ) u_slave (
      .io_clk    (io_clk),
      .io_rst    (io_rst),
      .bus       (bus),
      .o_wr      (w_wr),
      .o_reg_hit (w_reg_hit),
      .o_reg_idx (w_reg_idx),
      .i_rd_data (w_rd_data)
   );

   assign w_wdata = bus.io_write_data;
   assign w_be    = bus.io_byte_enable;

   assign w_wr_ctrl    = w_wr && w_reg_hit && (w_reg_idx == OFS_CTRL) && w_be[0];
   assign w_wr_load    = w_wr && w_reg_hit && (w_reg_idx == OFS_LOAD);
   assign w_wr_count   = w_wr && w_reg_hit && (w_reg_idx == OFS_COUNT);
   assign w_wr_pre     = w_wr && w_reg_hit && (w_reg_idx == OFS_PRESCALE);
   assign w_status_clr = w_wr && w_reg_hit && (w_reg_idx == OFS_STATUS) &&
                         w_be[0] && w_wdata[0];

   assign w_tick   = r_en && (r_pre_cnt == r_prescale);
   assign w_expire = w_tick && (r_count == '0);

   always_comb begin
      w_pre_wr_val = r_prescale;
      for (int i = 0; i < PRESCALE_WIDTH; i++)
         if (w_be[i/8]) w_pre_wr_val[i] = w_wdata[i];
   end

   always_comb begin
      w_rd_data = '0;
      if (w_reg_hit) begin
         case (w_reg_idx)
            OFS_CTRL:     w_rd_data = {29'd0, r_irq_en, r_auto, r_en};
            OFS_LOAD:     w_rd_data = r_load;
            OFS_COUNT:    w_rd_data = r_count;
            OFS_STATUS:   w_rd_data = {31'd0, r_expired};
            OFS_PRESCALE: w_rd_data = 32'(r_prescale);
            default:      w_rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge io_clk or posedge io_rst) begin
      if (io_rst) begin
         r_en       <= 1'b0;
         r_auto     <= 1'b0;
         r_irq_en   <= 1'b0;
         r_load     <= '0;
         r_count    <= '0;
         r_expired  <= 1'b0;
         r_prescale <= '0;
         r_pre_cnt  <= '0;
         r_irq      <= 1'b0;
      end else begin
         if (!r_en || w_tick) r_pre_cnt <= '0;
         else                 r_pre_cnt <= r_pre_cnt + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

         // A bus write to COUNT replaces the tick update for that cycle.
         if (w_wr_count)
            r_count <= be_merge(r_count, w_wdata, w_be);
         else if (w_tick) begin
            if (r_count != '0) r_count <= r_count - 32'd1;
            else if (r_auto)   r_count <= r_load;
         end

         if (w_wr_ctrl) begin
            r_en     <= w_wdata[CTRL_EN];
            r_auto   <= w_wdata[CTRL_AUTO_RELOAD];
            r_irq_en <= w_wdata[CTRL_IRQ_EN];
         end else if (w_expire && !r_auto) begin
            r_en <= 1'b0;
         end

         if (w_wr_load) r_load     <= be_merge(r_load, w_wdata, w_be);
         if (w_wr_pre)  r_prescale <= w_pre_wr_val;

         if (w_expire)          r_expired <= 1'b1;
         else if (w_status_clr) r_expired <= 1'b0;

         r_irq <= r_expired && r_irq_en;
      end
   end

   assign irq = r_irq;

endmodule
